// File: rtl/handshake_width_pack_if.sv
// Word-in / beat-out handshake bundle for the width packer.
// slave is the packer's view; master is the surrounding producer/consumer.
interface handshake_width_pack_if #(
  parameter int WORD_WIDTH = 32,
  parameter int RATIO      = 4
);
  logic                        up_valid;
  logic [WORD_WIDTH-1:0]       up_data;
  logic                        up_last;
  logic                        up_ready;
  logic                        down_valid;
  logic [WORD_WIDTH*RATIO-1:0] down_data;
  logic [RATIO-1:0]            down_keep;
  logic                        down_last;
  logic                        down_ready;

  modport master (
    output up_valid, up_data, up_last, down_ready,
    input  up_ready, down_valid, down_data, down_keep, down_last
  );

  modport slave (
    input  up_valid, up_data, up_last, down_ready,
    output up_ready, down_valid, down_data, down_keep, down_last
  );
endinterface

// File: rtl/handshake_width_pack.sv
// Packs RATIO words into one registered beat (lane 0 first), up_last closes a short beat.
// Latency 1 clk from completing word; stalls upstream while the output beat is held.
module handshake_width_pack #(
  parameter int WORD_WIDTH = 32,
  parameter int RATIO      = 4,
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  handshake_width_pack_if.slave bus
);

  localparam int BEAT_W = WORD_WIDTH * RATIO;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]  cnt;
  logic [BEAT_W-1:0] acc_data;
  logic [RATIO-1:0]  acc_keep;
  logic [BEAT_W-1:0] beat_data;
  logic [RATIO-1:0]  beat_keep;

  logic              out_valid;
  logic [BEAT_W-1:0] out_data;
  logic [RATIO-1:0]  out_keep;
  logic              out_last;

  logic up_ready;
  logic acc;
  logic out;
  logic complete;

  assign up_ready = !out_valid || bus.down_ready;
  assign acc      = bus.up_valid && up_ready;
  assign out      = out_valid && bus.down_ready;
  assign complete = acc && ((cnt == CNT_MAX) || bus.up_last);

  // Accumulator with the incoming word merged into lane cnt; feeds both the
  // accumulator itself and the output register on completion.
  always_comb begin
    beat_data = acc_data;
    beat_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) == cnt) begin
        beat_data[i*WORD_WIDTH +: WORD_WIDTH] = bus.up_data;
        beat_keep[i]                          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (complete) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (acc) begin
      cnt      <= cnt + 1'b1;
      acc_data <= beat_data;
      acc_keep <= beat_keep;
    end
  end

  // Output register: a completion reloads it even while the old beat leaves,
  // so consecutive beats go out without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_keep  <= beat_keep;
      out_last  <= bus.up_last;
    end else if (out) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.up_ready   = up_ready;
  assign bus.down_valid = out_valid;
  assign bus.down_data  = out_data;
  assign bus.down_keep  = out_keep;
  assign bus.down_last  = out_last;

endmodule

// File: tb/tb_handshake_width_pack.sv
// Bench for handshake_width_pack: directed scenarios plus random traffic against a queue-based packing model.
module tb_handshake_width_pack;

  localparam int W = 32;
  localparam int R = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  handshake_width_pack_if #(.WORD_WIDTH(W), .RATIO(R)) bus ();

  handshake_width_pack #(.WORD_WIDTH(W), .RATIO(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words of the open group, and the beat the consumer should see.
  logic [W-1:0]   grp[$];
  logic           m_vld;
  logic [W*R-1:0] m_data;
  logic [R-1:0]   m_keep;
  logic           m_last;

  task automatic model_reset();
    grp.delete();
    m_vld  = 1'b0;
    m_data = '0;
    m_keep = '0;
    m_last = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the model across the posedge, return at the next negedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                      input logic dr, output logic accepted);
    logic           cmpl;
    logic [W*R-1:0] nd;
    logic [R-1:0]   nk;
    bus.up_valid   = v;
    bus.up_data    = d;
    bus.up_last    = l;
    bus.down_ready = dr;
    accepted = v && (!m_vld || dr);
    cmpl = 1'b0;
    nd = '0;
    nk = '0;
    if (accepted) begin
      grp.push_back(d);
      if (grp.size() == R || l) begin
        foreach (grp[k]) begin
          nd[k*W +: W] = grp[k];
          nk[k]        = 1'b1;
        end
        cmpl = 1'b1;
        grp.delete();
      end
    end
    @(posedge clk);
    if (cmpl) begin
      m_vld  = 1'b1;
      m_data = nd;
      m_keep = nk;
      m_last = l;
    end else if (m_vld && dr) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, a);
  endtask

  task automatic test_reset();
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_last    = 1'b0;
    bus.down_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.down_valid !== 1'b0 || bus.down_data !== '0 || bus.down_keep !== '0 || bus.down_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h k=%b l=%b want all zero",
               bus.down_valid, bus.down_data, bus.down_keep, bus.down_last);
    end
    checks++;
    if (bus.up_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_up_ready: got %b want 1", bus.up_ready);
    end
  endtask

  task automatic test_full_packet();
    logic [W-1:0] w[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic a;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[i], i == 3, 1'b1, a);
      checks++;
      if (bus.down_valid !== (i == 3)) begin
        errors++;
        $display("FAIL full_valid_timing word %0d: got %b want %b", i, bus.down_valid, i == 3);
      end
    end
    checks++;
    if (bus.down_data !== 128'h00000044_00000033_00000022_00000011 || bus.down_keep !== 4'b1111 || bus.down_last !== 1'b1) begin
      errors++;
      $display("FAIL full_beat: got d=%h k=%b l=%b want d=00000044000000330000002200000011 k=1111 l=1",
               bus.down_data, bus.down_keep, bus.down_last);
    end
    idle(1);
    checks++;
    if (bus.down_valid !== 1'b0 || bus.down_data !== 128'h00000044_00000033_00000022_00000011 || bus.down_keep !== 4'b1111) begin
      errors++;
      $display("FAIL full_drain_hold: got v=%b d=%h k=%b want v=0 with data/keep held",
               bus.down_valid, bus.down_data, bus.down_keep);
    end
  endtask

  task automatic test_short_packet();
    logic a;
    step(1'b1, 32'hA1, 1'b0, 1'b1, a);
    step(1'b1, 32'hA2, 1'b1, 1'b1, a);
    checks++;
    if (bus.down_valid !== 1'b1 || bus.down_data !== 128'h000000A2_000000A1 || bus.down_keep !== 4'b0011 || bus.down_last !== 1'b1) begin
      errors++;
      $display("FAIL short_beat: got v=%b d=%h k=%b l=%b want v=1 d=..a2000000a1 k=0011 l=1",
               bus.down_valid, bus.down_data, bus.down_keep, bus.down_last);
    end
    idle(1);
    step(1'b1, 32'hC1, 1'b1, 1'b1, a);
    checks++;
    if (bus.down_valid !== 1'b1 || bus.down_data !== 128'h000000C1 || bus.down_keep !== 4'b0001 || bus.down_last !== 1'b1) begin
      errors++;
      $display("FAIL lane0_last_beat: got v=%b d=%h k=%b l=%b want v=1 d=..c1 k=0001 l=1",
               bus.down_valid, bus.down_data, bus.down_keep, bus.down_last);
    end
    idle(1);
  endtask

  task automatic test_stream();
    logic a;
    int beats = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h100 + i, 1'b0, 1'b1, a);
      if (bus.down_valid === 1'b1) beats++;
      checks++;
      if (bus.up_ready !== 1'b1 || bus.down_valid !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL stream_cycle %0d: got rdy=%b v=%b want rdy=1 v=%b", i, bus.up_ready, bus.down_valid, (i % 4) == 3);
      end
      if ((i % 4) == 3) begin
        checks++;
        if (bus.down_data !== {32'h100 + i, 32'h100 + i - 1, 32'h100 + i - 2, 32'h100 + i - 3} || bus.down_keep !== 4'b1111 || bus.down_last !== 1'b0) begin
          errors++;
          $display("FAIL stream_beat %0d: got d=%h k=%b l=%b", i, bus.down_data, bus.down_keep, bus.down_last);
        end
      end
    end
    checks++;
    if (beats != 3) begin
      errors++;
      $display("FAIL stream_beat_count: got %0d want 3", beats);
    end
    idle(1);
  endtask

  task automatic test_stall();
    logic [W-1:0]   w[8];
    logic [W*R-1:0] first;
    logic           a;
    int             n;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    first = {w[3], w[2], w[1], w[0]};
    for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, 1'b1, a);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, w[4], 1'b0, 1'b0, a);
      checks++;
      if (bus.up_ready !== 1'b0 || bus.down_valid !== 1'b1 || bus.down_data !== first || bus.down_keep !== 4'b1111) begin
        errors++;
        $display("FAIL stall_cycle %0d: got rdy=%b v=%b d=%h k=%b want rdy=0 v=1 d=%h k=1111",
                 c, bus.up_ready, bus.down_valid, bus.down_data, bus.down_keep, first);
      end
    end
    n = 4;
    for (int c = 0; c < 20 && n < 8; c++) begin
      step(1'b1, w[n], 1'b0, 1'b1, a);
      if (a) n++;
    end
    checks++;
    if (n != 8 || bus.down_valid !== 1'b1 || bus.down_data !== {w[7], w[6], w[5], w[4]} || bus.down_keep !== 4'b1111) begin
      errors++;
      $display("FAIL stall_next_group: got n=%0d v=%b d=%h want n=8 v=1 d=%h",
               n, bus.down_valid, bus.down_data, {w[7], w[6], w[5], w[4]});
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    logic a;
    step(1'b1, 32'hD0, 1'b1, 1'b0, a);
    step(1'b1, 32'hD1, 1'b1, 1'b0, a);
    for (int i = 1; i <= 4; i++) begin
      w = 32'hD0 + i;
      step(1'b1, w, 1'b1, 1'b1, a);
      checks++;
      if (bus.down_valid !== 1'b1 || bus.down_data !== {96'h0, w} || bus.down_keep !== 4'b0001 || bus.down_last !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back %0d: got v=%b d=%h k=%b want v=1 d=%h k=0001", i, bus.down_valid, bus.down_data, bus.down_keep, w);
      end
    end
    idle(1);
  endtask

  task automatic test_async_reset();
    logic a;
    for (int i = 0; i < 4; i++) step(1'b1, 32'hE0 + i, 1'b0, 1'b0, a);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.down_valid !== 1'b0 || bus.down_data !== '0 || bus.down_keep !== '0) begin
      errors++;
      $display("FAIL async_reset_pending: got v=%b d=%h k=%b want all zero", bus.down_valid, bus.down_data, bus.down_keep);
    end
    model_reset();
    bus.up_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hF1, 1'b0, 1'b1, a);
    step(1'b1, 32'hF2, 1'b0, 1'b1, a);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_midgroup: got v=%b rdy=%b want v=0 rdy=1", bus.down_valid, bus.up_ready);
    end
    model_reset();
    bus.up_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hB1, 1'b1, 1'b1, a);
    checks++;
    if (bus.down_valid !== 1'b1 || bus.down_data !== 128'h000000B1 || bus.down_keep !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_lane0: got v=%b d=%h k=%b want v=1 d=..b1 k=0001", bus.down_valid, bus.down_data, bus.down_keep);
    end
    idle(1);
  endtask

  task automatic test_random();
    logic a;
    logic v, l, dr;
    for (int c = 0; c < 600; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 4) == 0);
      dr = ($urandom_range(0, 3) != 0);
      step(v, $urandom, l, dr, a);
      checks++;
      if (bus.down_valid !== m_vld || bus.down_data !== m_data || bus.down_keep !== m_keep ||
          bus.down_last !== m_last || bus.up_ready !== (!m_vld || dr)) begin
        errors++;
        $display("FAIL random cycle %0d: got v=%b d=%h k=%b l=%b rdy=%b want v=%b d=%h k=%b l=%b rdy=%b",
                 c, bus.down_valid, bus.down_data, bus.down_keep, bus.down_last, bus.up_ready,
                 m_vld, m_data, m_keep, m_last, !m_vld || dr);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_full_packet();
    test_short_packet();
    test_stream();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
